// File: rtl/md_unit.sv
// Purpose: multi-cycle multiply/divide unit that owns the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Latency: MTHI/MTLO write at the start edge; mult/div keep busy high for MULT_CYCLES/DIV_CYCLES and then write HI/LO.
// Backpressure: md_stall holds a later md-class op in Decode while busy; any start seen while busy is ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt;
    logic [2:0]    opReg;
    logic [31:0]   aReg, bReg;
    logic          launch, finish, idleStart;

    logic [63:0]   extA, extB, prod;
    logic          negA, negB;
    logic [31:0]   magA, magB, divisor, qMag, rMag, quo, rem;
    logic [31:0]   resHi, resLo;
    logic          divByZero;

    // Arithmetic ops are exactly the codes with bit 2 clear.
    assign idleStart = (state == IDLE) && start;
    assign busy      = (state == RUN);
    assign md_stall  = d_is_md & (busy | (start & ~md_op[2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !md_op[2]) begin
                    launch    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    finish    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // One 64-bit multiplier serves both flavours: sign- or zero-extend, keep the low 64 bits.
    always_comb begin
        extA = {{32{aReg[31] & ~opReg[0]}}, aReg};
        extB = {{32{bReg[31] & ~opReg[0]}}, bReg};
        prod = extA * extB;

        // Divide on magnitudes, then restore signs: quotient truncates toward zero,
        // remainder follows the dividend. 0x80000000/-1 falls out as 0x80000000 rem 0.
        negA      = ~opReg[0] & aReg[31];
        negB      = ~opReg[0] & bReg[31];
        magA      = negA ? -aReg : aReg;
        magB      = negB ? -bReg : bReg;
        divByZero = (bReg == 32'd0);
        divisor   = divByZero ? 32'd1 : magB;
        qMag      = magA / divisor;
        rMag      = magA % divisor;
        quo       = (negA ^ negB) ? -qMag : qMag;
        rem       = negA ? -rMag : rMag;

        resHi = opReg[1] ? rem : prod[63:32];
        resLo = opReg[1] ? quo : prod[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            opReg <= '0;
            aReg  <= '0;
            bReg  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (launch) begin
                aReg  <= src_a;
                bReg  <= src_b;
                opReg <= md_op;
                cnt   <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end

            if (idleStart && md_op == OP_MTHI) hi <= src_a;
            if (idleStart && md_op == OP_MTLO) lo <= src_a;

            // A zero divisor still burns the full latency but leaves HI/LO alone.
            if (finish && !(opReg[1] && divByZero)) begin
                hi <= resHi;
                lo <= resLo;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Randomised bench for md_unit against a 64-bit arithmetic reference of HI/LO.
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk, rst_n, start, d_is_md;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        busy, md_stall;
    logic [31:0] hi, lo;

    logic [31:0] mHi, mLo;
    int          nChecks, nPass;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .d_is_md(d_is_md),
        .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Reference: plain 64-bit integer arithmetic on the operands as issued.
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, pu, qu, ru;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sb; mHi = p[63:32]; mLo = p[31:0]; end
            3'd1: begin pu = ua * ub; mHi = pu[63:32]; mLo = pu[31:0]; end
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; mLo = q[31:0]; mHi = r[31:0]; end
            3'd3: if (b != 0) begin qu = ua / ub; ru = ua % ub; mLo = qu[31:0]; mHi = ru[31:0]; end
            3'd4: mHi = a;
            3'd5: mLo = a;
            default: ;
        endcase
    endtask

    task automatic doOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic dmd;
        int   n, expN;
        dmd = 1'($urandom_range(0, 1));
        start = 1'b1; md_op = op; src_a = a; src_b = b; d_is_md = dmd;
        #1;
        check("stall_start", 32'(md_stall), 32'(dmd & (op inside {3'd0, 3'd1, 3'd2, 3'd3})));
        modelOp(op, a, b);
        @(posedge clk); #1;
        start = 1'b0; d_is_md = 1'b0;
        src_a = $urandom; src_b = $urandom;
        if (op inside {3'd0, 3'd1, 3'd2, 3'd3}) begin
            expN = (op inside {3'd2, 3'd3}) ? DIV_N : MULT_N;
            n = 0;
            while (busy && n < 200) begin
                dmd = 1'($urandom_range(0, 1));
                d_is_md = dmd;
                #1;
                check("stall_busy", 32'(md_stall), 32'(dmd));
                if (inject && $urandom_range(0, 2) == 0) begin
                    start = 1'b1; md_op = 3'($urandom_range(0, 7));
                    src_a = $urandom; src_b = $urandom;
                end
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
            check("busy_cycles", 32'(n), 32'(expN));
        end else begin
            check("no_busy", 32'(busy), 32'd0);
        end
        d_is_md = 1'b0;
        check("hi", hi, mHi);
        check("lo", lo, mLo);
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_hi"}, hi, 32'd0);
        check({tag, "_lo"}, lo, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        nChecks = 0; nPass = 0;
        mHi = '0; mLo = '0;
        rst_n = 1'b0; start = 1'b0; md_op = '0; src_a = '0; src_b = '0; d_is_md = 1'b0;
        #1;
        checkZero("reset");
        check("reset_stall", 32'(md_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        doOp(3'd4, 32'h0000_1234, 32'h0, 1'b0);
        doOp(3'd5, 32'h0000_5678, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkZero("reset_seq");
        mHi = '0; mLo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        doOp(3'd4, 32'hDEAD_0000, 32'h0, 1'b0);
        check("mthi_const", hi, 32'hDEAD_0000);

        doOp(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        doOp(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        doOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        doOp(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);
        doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        doOp(3'd4, 32'hAAAA_5555, 32'h0, 1'b0);
        doOp(3'd5, 32'h5555_AAAA, 32'h0, 1'b0);
        doOp(3'd2, 32'h0000_1234, 32'd0, 1'b1);
        check("dz_hi", hi, 32'hAAAA_5555);
        check("dz_lo", lo, 32'h5555_AAAA);

        for (int i = 0; i < 60; i++)
            doOp(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);

        // Abort a DIV partway through with an asynchronous reset.
        start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 checkZero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (DIV_N + 2) @(posedge clk);
        #1 checkZero("post_abort");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the Execute stage, holding the architectural HI/LO registers.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces a stall request that is OR-ed into the Decode-stage stall logic, so a later mult/div/mfhi/mflo/mthi/mtlo waits in Decode while an operation is in flight.
- Reads of HI/LO for MFHI/MFLO are combinational from the hi/lo outputs.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (legal range ≥1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (legal range ≥1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  E-stage instruction is an md-class op this cycle; single-cycle pulse per instruction.
- md_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- src_a  input  32  rs operand (forwarded value).
- src_b  input  32  rt operand (forwarded value).
- d_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in flight.
- md_stall  output  1  stall request to the Decode stall logic.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: while rst_n=0, hi=0, lo=0, busy=0, counter=0, operand/op latches=0. Asynchronous assert, synchronous release. Reset mid-operation aborts it; HI/LO stay 0.
- States:
  - IDLE (busy=0).
  - RUN (busy=1), with a down-counter cnt.
- IDLE, start=1, op ∈ {MULT, MULTU, DIV, DIVU}:
  - Latch src_a, src_b and op.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=MTHI: hi<=src_a at that edge; no busy.
- IDLE, start=1, op=MTLO: lo<=src_a at that edge; no busy.
- IDLE, start=1, reserved op: no effect.
- RUN, each edge: cnt decrements.
- RUN, edge where cnt==1:
  - Write hi/lo from the latched result.
  - Return to IDLE.
  - busy therefore stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - New hi/lo are visible the cycle busy falls.
- start while busy=1: ignored entirely, no latch and no HI/LO write. Upstream stall guarantees this never happens legally.
- MULT: signed 32x32 -> 64; hi=prod[63:32], lo=prod[31:0].
- MULTU: unsigned 32x32 -> 64; same split as MULT.
- DIV: signed division, quotient truncated toward zero; lo=quotient, hi=remainder. The remainder takes the sign of the dividend.
- DIVU: unsigned division; lo=quotient, hi=remainder.
- Divide by zero (latched src_b==0): runs the full DIV_CYCLES, then leaves hi/lo unchanged.
- DIV overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- Result computation:
  - May be combinational on the latched operands, registered at the final edge.
  - Arithmetic uses the latched operands only; src_a/src_b changes after start are irrelevant.
- md_stall = d_is_md & (busy | (start & op ∈ {MULT, MULTU, DIV, DIVU})). Purely combinational, no register delay.
- Simultaneous completion edge and a new start: impossible, because start is ignored while busy.
- A start on the cycle immediately after busy falls is accepted normally.

Test Plan:
- Reset sequence:
  - MTHI 0x1234 then MTLO 0x5678; assert rst_n=0 mid-sequence and release.
  - Required: hi=lo=0, busy=0.
  - Then MTHI src_a=0xDEAD0000 requires hi=0xDEAD0000 the next cycle, with busy never asserting.
- Signed MULT:
  - MULT src_a=0xFFFFFFFE (-2), src_b=3.
  - Required: busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands requires hi=0x00000002, lo=0xFFFFFFFA.
- DIV sign rules:
  - DIV -7/2 requires lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - DIVU 7/2 requires lo=3, hi=1.
  - DIV 0x80000000/0xFFFFFFFF requires lo=0x80000000, hi=0.
- Divide by zero:
  - Preload hi=0xAAAA5555, lo=0x5555AAAA, then DIV x/0.
  - Required: busy for 10 cycles; hi/lo unchanged.
- Stall interlock:
  - During MULT busy, hold d_is_md=1: md_stall=1 on every busy cycle and on the start cycle.
  - d_is_md=0: md_stall=0.
  - Inject start (MTLO) mid-busy: lo unchanged, result unaffected.
  - Back-to-back start on the cycle busy falls: accepted, busy re-asserts the next cycle.
- Reset mid-operation:
  - Assert rst_n=0 during cycle 3 of DIV.
  - Required: busy=0 and hi=lo=0 immediately (asynchronous); no late hi/lo write after release.
